// File: rtl/mips_divider.sv
// Iterative restoring divider for MIPS32 DIV/DIVU: quotient to LO, remainder to HI.
// Latency: WIDTH+1 cycles from the start-sampling edge to the done pulse.
// Backpressure: none; busy stalls the caller, and start while busy is dropped.
//
// Optional feature macro: DIVIDER_SIGNED_EN. When it is defined, is_signed selects DIV
// (two's complement). When it is undefined, every operation is DIVU and no
// negation logic is built.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   start              request, sampled only when idle
//   is_signed          1 = DIV, 0 = DIVU (captured with start)
//   dividend, divisor  rs / rt operands (captured with start)
//   busy               operation in flight
//   done               one-cycle pulse when results update
//   quotient           LO result, held until the next completion
//   remainder          HI result, held until the next completion
//   div_by_zero        divisor was zero, held with the results
module mips_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] part_rem;   // partial remainder
    logic [WIDTH-1:0] dq;         // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] div_mag;    // divisor magnitude
    logic             dz;

    // Operand magnitudes, and the sign-corrected results used in the SIGN state.
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

`ifdef DIVIDER_SIGNED_EN
    logic q_neg;
    logic r_neg;
    logic dividend_neg;
    logic divisor_neg;

    always_comb begin
        dividend_neg = is_signed & dividend[WIDTH-1];
        divisor_neg  = is_signed & divisor[WIDTH-1];
        // The most-negative value maps to itself, which is the correct
        // unsigned magnitude, so the wrap in the negation is harmless.
        dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
        divisor_mag  = divisor_neg  ? (~divisor + 1'b1)  : divisor;
        quot_fix     = q_neg ? (~dq + 1'b1)       : dq;
        rem_fix      = r_neg ? (~part_rem + 1'b1) : part_rem;
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;

    always_comb begin
        dividend_mag = dividend;
        divisor_mag  = divisor;
        quot_fix     = dq;
        rem_fix      = part_rem;
    end
`endif

    // One restoring step: bring in the next dividend bit, then subtract the
    // divisor at WIDTH+1 bits. Bit WIDTH of the difference is the borrow, so
    // it is set exactly when the trial result is negative.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {part_rem, dq[WIDTH-1]};
        trial   = shifted - {1'b0, div_mag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            part_rem    <= '0;
            dq          <= '0;
            div_mag     <= '0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dq       <= dividend_mag;
                        div_mag  <= divisor_mag;
                        part_rem <= '0;
                        count    <= '0;
                        dz       <= (divisor == '0);
`ifdef DIVIDER_SIGNED_EN
                        q_neg    <= dividend_neg ^ divisor_neg;
                        r_neg    <= dividend_neg;
`endif
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (!trial[WIDTH]) begin
                        part_rem <= trial[WIDTH-1:0];
                        dq       <= {dq[WIDTH-2:0], 1'b1};
                    end else begin
                        // Restore: keep the shifted remainder and leave the divisor unsubtracted.
                        part_rem <= shifted[WIDTH-1:0];
                        dq       <= {dq[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    quotient    <= quot_fix;
                    remainder   <= rem_fix;
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
